// File: rtl/br_delay_valid_next_rx_pkg.sv
// Shared helpers for the valid_next receive FIFO: width sizing and pointer wrap.
package br_delay_valid_next_rx_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit compare so non-power-of-2 depths wrap correctly.
    function automatic int unsigned ptr_incr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/br_delay_valid_next_rx_storage.sv
// Flop array for the receive FIFO: registered write port, combinational read port, no reset.
module br_delay_valid_next_rx_storage #(
    parameter int Width     = 1,
    parameter int Depth     = 2,
    parameter int AddrWidth = 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [Width-1:0]     wr_data,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [Width-1:0]     rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/br_delay_valid_next_rx_fifo.sv
// Receive terminator for a valid_next delay line: captures beats one cycle after
// valid_next, presents them on a ready/valid pop port and returns one credit per pop.
module br_delay_valid_next_rx_fifo
    import br_delay_valid_next_rx_pkg::*;
#(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_next,
    input  logic [Width-1:0]              in,
    output logic                          credit_return,
    output logic                          pop_valid,
    input  logic                          pop_ready,
    output logic [Width-1:0]              pop_data,
    output logic [$clog2(Depth+1)-1:0]    items,
    output logic                          overflow_error
);

    localparam int PtrWidth   = ptr_width(Depth);
    localparam int CountWidth = count_width(Depth);

    logic                  push_pending;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  pop;
    logic                  full;
    logic                  push_accept;
    logic                  overflow;

    assign pop       = pop_valid & pop_ready;
    assign full      = (count == CountWidth'(Depth));
    // When full, a same-cycle pop frees the very slot the write lands in.
    assign push_accept = push_pending & (~full | pop);
    assign overflow    = push_pending & full & ~pop;

    assign pop_valid = (count != '0);
    assign items     = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_pending   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            credit_return  <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            push_pending   <= in_valid_next;
            credit_return  <= pop;
            overflow_error <= overflow_error | overflow;
            if (push_accept) begin
                wr_ptr <= PtrWidth'(ptr_incr(32'(wr_ptr), Depth));
            end
            if (pop) begin
                rd_ptr <= PtrWidth'(ptr_incr(32'(rd_ptr), Depth));
            end
            if (push_accept && !pop) begin
                count <= count + CountWidth'(1);
            end else if (!push_accept && pop) begin
                count <= count - CountWidth'(1);
            end
        end
    end

    br_delay_valid_next_rx_storage #(
        .Width     (Width),
        .Depth     (Depth),
        .AddrWidth (PtrWidth)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_accept),
        .wr_addr (wr_ptr),
        .wr_data (in),
        .rd_addr (rd_ptr),
        .rd_data (pop_data)
    );

    // Consumer must never see a retraction of a stalled head.
    assert property (@(posedge clk) disable iff (!rst_n)
        (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_data)));

endmodule
